// File: rtl/fp_pkg.sv
// Shared FP32 field widths, special encodings and the accumulator state type.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned GRD_W = 3;

    // Significand with hidden bit and guard bits, plus one carry bit for the sum.
    localparam int unsigned SIG_W   = MAN_W + GRD_W + 1;
    localparam int unsigned SUM_W   = SIG_W + 1;
    localparam int unsigned EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the 28-bit sum; all-zero input yields 28.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [SUM_W-1:0] i_data,
    output logic [4:0]       o_count
);

    always_comb begin
        o_count = 5'(SUM_W);
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (i_data[i]) begin
                o_count = 5'(SUM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Iterative FP32 stream accumulator: one element per ALIGN/ADD/NORM pass, truncating
// rounding, denormal flush and a sticky overflow that pins the stream result to inf.
module fp_accumulator
    import fp_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf
);

    localparam logic [EXP_W+1:0] EXP_LIM = (EXP_W+2)'(EXP_MAX);

    state_t r_state, w_next;

    logic [31:0]        r_acc, r_op;
    logic               r_last, r_ovf;
    logic [EXP_W-1:0]   r_exp;
    logic [SIG_W-1:0]   r_mag_a, r_mag_b;
    logic               r_sgn_a, r_sgn_b;
    logic [SUM_W-1:0]   r_sum;
    logic               r_sgn_sum;

    logic [EXP_W-1:0]   w_exp_acc, w_exp_op, w_diff;
    logic [SIG_W-1:0]   w_sig_acc, w_sig_op, w_aligned;
    logic               w_acc_big;
    logic [SUM_W-1:0]   w_sum;
    logic               w_sgn_sum;
    logic [4:0]         w_lzc;
    logic [EXP_W+1:0]   w_exp_n;
    logic [MAN_W-1:0]   w_man;
    logic [31:0]        w_result;
    logic               w_result_ovf;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid && in_ready) w_next = ALIGN;
            ALIGN:   w_next = ADD;
            ADD:     w_next = NORM;
            NORM:    w_next = r_last ? OUT : IDLE;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_ovf   = 1'b0;
        if (reset_n) begin
            in_ready  = (r_state == IDLE);
            out_valid = (r_state == OUT);
            out_sum   = r_acc;
            out_ovf   = r_ovf;
        end
    end

    // ALIGN: a zero exponent field flushes the operand to a zero significand.
    always_comb begin
        w_exp_acc = r_acc[MAN_W+EXP_W-1:MAN_W];
        w_exp_op  = r_op[MAN_W+EXP_W-1:MAN_W];
        w_sig_acc = (w_exp_acc == '0) ? '0 : {1'b1, r_acc[MAN_W-1:0], {GRD_W{1'b0}}};
        w_sig_op  = (w_exp_op  == '0) ? '0 : {1'b1, r_op[MAN_W-1:0],  {GRD_W{1'b0}}};
        w_acc_big = (w_exp_acc >= w_exp_op);
        w_diff    = w_acc_big ? (w_exp_acc - w_exp_op) : (w_exp_op - w_exp_acc);
        if (w_diff >= EXP_W'(SIG_W + 1)) begin
            w_aligned = '0;
        end else begin
            w_aligned = (w_acc_big ? w_sig_op : w_sig_acc) >> w_diff;
        end
    end

    always_comb begin
        if (r_sgn_a == r_sgn_b) begin
            w_sum     = {1'b0, r_mag_a} + {1'b0, r_mag_b};
            w_sgn_sum = r_sgn_a;
        end else if (r_mag_a >= r_mag_b) begin
            w_sum     = {1'b0, r_mag_a} - {1'b0, r_mag_b};
            w_sgn_sum = r_sgn_a;
        end else begin
            w_sum     = {1'b0, r_mag_b} - {1'b0, r_mag_a};
            w_sgn_sum = r_sgn_b;
        end
    end

    // Count zeros below the carry bit so a sum already at the hidden position yields 0.
    fp_lzc u_lzc (
        .i_data  ({r_sum[SIG_W-1:0], 1'b0}),
        .o_count (w_lzc)
    );

    always_comb begin
        if (r_sum[SUM_W-1]) begin
            w_exp_n = {2'b00, r_exp} + (EXP_W+2)'(1);
            w_man   = r_sum[SUM_W-2:GRD_W+1];
        end else begin
            w_exp_n = {2'b00, r_exp} - {5'b00000, w_lzc};
            w_man   = MAN_W'((r_sum[SIG_W-2:0] << w_lzc) >> GRD_W);
        end

        w_result     = r_acc;
        w_result_ovf = r_ovf;
        if (r_ovf) begin
            w_result = r_acc;
        end else if (w_exp_op == '1) begin
            w_result     = r_op[31] ? FP_NINF : FP_PINF;
            w_result_ovf = 1'b1;
        end else if (r_sum == '0 || w_exp_n[EXP_W+1] || w_exp_n == '0) begin
            w_result = FP_ZERO;
        end else if (w_exp_n >= EXP_LIM) begin
            w_result     = r_sgn_sum ? FP_NINF : FP_PINF;
            w_result_ovf = 1'b1;
        end else begin
            w_result = {r_sgn_sum, w_exp_n[EXP_W-1:0], w_man};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc  <= FP_ZERO;
            r_ovf  <= 1'b0;
            r_last <= 1'b0;
            r_op   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op   <= in_data;
                        r_last <= in_last;
                    end
                end
                ALIGN: begin
                    r_exp   <= w_acc_big ? w_exp_acc : w_exp_op;
                    r_mag_a <= w_acc_big ? w_sig_acc : w_sig_op;
                    r_sgn_a <= w_acc_big ? r_acc[31] : r_op[31];
                    r_mag_b <= w_aligned;
                    r_sgn_b <= w_acc_big ? r_op[31] : r_acc[31];
                end
                ADD: begin
                    r_sum     <= w_sum;
                    r_sgn_sum <= w_sgn_sum;
                end
                NORM: begin
                    r_acc <= w_result;
                    r_ovf <= w_result_ovf;
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc <= FP_ZERO;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
